// File: rtl/beam_topk_sort.sv
// =============================================================================
// beam_topk_sort
// -----------------------------------------------------------------------------
// Streaming top-K beam selector feeding the codeword selection stage.
//
// Per RBG the block receives NBEAM_IN unsigned beam powers in beam order, one
// per valid cycle, the first one flagged with i_pwr_sop. A sorted list of the
// BEAM strongest beams is maintained on the fly (one parallel insert per
// accepted sample). One cycle after the last beam of an RBG (the FLUSH cycle)
// the list is copied to the registered outputs. o_rbg_load is high for exactly
// the first cycle in which the new copy is visible.
//
// Ports
//   i_clk        clock
//   i_reset_n    synchronous reset, active low
//   i_pwr_vld    beam power sample valid
//   i_pwr_sop    qualifies i_pwr_vld: sample is beam 0 of a new RBG
//   i_pwr_data   unsigned beam power (PWR_W bits)
//   o_beam_idx   [BEAM-1:0][7:0] beam indices, entry 0 = strongest
//   o_beam_pwr   [BEAM-1:0][PWR_W-1:0] matching powers, same ordering
//   o_rbg_load   1-cycle pulse: o_beam_idx/o_beam_pwr updated this cycle
//   o_busy       high while an RBG is partially collected
//   o_err_sop    1-cycle pulse on a framing error
//
// Parameters
//   NBEAM_IN     beams per RBG, BEAM <= NBEAM_IN <= 128
//   BEAM         number of strongest beams kept
//   PWR_W        beam power width
// =============================================================================
module beam_topk_sort #(
    parameter int NBEAM_IN = 64,
    parameter int BEAM     = 16,
    parameter int PWR_W    = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_pwr_vld,
    input  logic                        i_pwr_sop,
    input  logic [PWR_W-1:0]            i_pwr_data,
    output logic [BEAM-1:0][7:0]        o_beam_idx,
    output logic [BEAM-1:0][PWR_W-1:0]  o_beam_pwr,
    output logic                        o_rbg_load,
    output logic                        o_busy,
    output logic                        o_err_sop
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // Counter value of the beam that closes an RBG.
    localparam logic [6:0] CNT_LAST_C = 7'(NBEAM_IN - 1);
    // A one-beam RBG is complete as soon as its sop sample is taken.
    localparam bit         SINGLE_C   = (NBEAM_IN == 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                         state_r;
    logic [6:0]                     cnt_r;
    logic [BEAM-1:0][PWR_W-1:0]     list_pwr_r;
    logic [BEAM-1:0][7:0]           list_idx_r;
    logic [BEAM-1:0]                list_vld_r;

    logic [BEAM-1:0][7:0]           beam_idx_r;
    logic [BEAM-1:0][PWR_W-1:0]     beam_pwr_r;
    logic                           rbg_load_r;
    logic                           busy_r;
    logic                           err_sop_r;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                           start_s;      // vld & sop
    logic                           beam_s;       // vld & !sop
    logic [7:0]                     sample_idx_s;
    logic [BEAM-1:0]                ge_s;         // entry i stays above the sample
    logic [BEAM-1:0][PWR_W-1:0]     ins_pwr_s;
    logic [BEAM-1:0][7:0]           ins_idx_s;
    logic [BEAM-1:0]                ins_vld_s;
    logic [BEAM-1:0][PWR_W-1:0]     init_pwr_s;
    logic [BEAM-1:0][7:0]           init_idx_s;
    logic [BEAM-1:0]                init_vld_s;

    assign start_s      = i_pwr_vld &  i_pwr_sop;
    assign beam_s       = i_pwr_vld & ~i_pwr_sop;
    assign sample_idx_s = {1'b0, cnt_r};

    // Parallel compare of the incoming sample against every list entry.
    // Valid entries form a prefix and are sorted descending, so ge_s is a
    // run of ones followed by zeros; its length is the insert position.
    // Equal powers count as "stay above", so an equal beam never displaces
    // an earlier one and ties resolve to the lower beam index.
    always_comb begin
        ge_s = '0;
        for (int i = 0; i < BEAM; i++) begin
            ge_s[i] = list_vld_r[i] & (list_pwr_r[i] >= i_pwr_data);
        end
    end

    // Insert: entries above the position keep their slot, the first entry
    // below takes the sample and every later entry takes its upper
    // neighbour, dropping the last one. If all entries stay above, the
    // list is unchanged.
    always_comb begin
        ins_pwr_s = list_pwr_r;
        ins_idx_s = list_idx_r;
        ins_vld_s = list_vld_r;
        if (!ge_s[0]) begin
            ins_pwr_s[0] = i_pwr_data;
            ins_idx_s[0] = sample_idx_s;
            ins_vld_s[0] = 1'b1;
        end else begin
            ins_pwr_s[0] = list_pwr_r[0];
            ins_idx_s[0] = list_idx_r[0];
            ins_vld_s[0] = list_vld_r[0];
        end
        for (int i = 1; i < BEAM; i++) begin
            if (ge_s[i]) begin
                ins_pwr_s[i] = list_pwr_r[i];
                ins_idx_s[i] = list_idx_r[i];
                ins_vld_s[i] = list_vld_r[i];
            end else if (ge_s[i-1]) begin
                ins_pwr_s[i] = i_pwr_data;
                ins_idx_s[i] = sample_idx_s;
                ins_vld_s[i] = 1'b1;
            end else begin
                ins_pwr_s[i] = list_pwr_r[i-1];
                ins_idx_s[i] = list_idx_r[i-1];
                ins_vld_s[i] = list_vld_r[i-1];
            end
        end
    end

    // List contents when a new RBG starts: only the sop sample (beam 0).
    always_comb begin
        init_pwr_s    = '0;
        init_idx_s    = '0;
        init_vld_s    = '0;
        init_pwr_s[0] = i_pwr_data;
        init_idx_s[0] = 8'd0;
        init_vld_s[0] = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Control FSM, sorted list and registered outputs.
    // -------------------------------------------------------------------------
    // FSM with list update, output copy and status pulses.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 7'd0;
            list_pwr_r <= '0;
            list_idx_r <= '0;
            list_vld_r <= '0;
            for (int i = 0; i < BEAM; i++) begin
                beam_idx_r[i] <= 8'(i);
            end
            beam_pwr_r <= '0;
            rbg_load_r <= 1'b0;
            busy_r     <= 1'b0;
            err_sop_r  <= 1'b0;
        end else begin
            // Pulses default low; only the branches below raise them.
            rbg_load_r <= 1'b0;
            err_sop_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        list_pwr_r <= init_pwr_s;
                        list_idx_r <= init_idx_s;
                        list_vld_r <= init_vld_s;
                        cnt_r      <= 7'd1;
                        state_r    <= SINGLE_C ? ST_FLUSH : ST_COLLECT;
                        busy_r     <= !SINGLE_C;
                    end else if (beam_s) begin
                        // Beam without a preceding sop: dropped.
                        err_sop_r  <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end

                ST_COLLECT: begin
                    if (start_s) begin
                        // Early sop: the partial RBG is thrown away and the
                        // new one starts with this sample.
                        err_sop_r  <= 1'b1;
                        list_pwr_r <= init_pwr_s;
                        list_idx_r <= init_idx_s;
                        list_vld_r <= init_vld_s;
                        cnt_r      <= 7'd1;
                        state_r    <= SINGLE_C ? ST_FLUSH : ST_COLLECT;
                        busy_r     <= !SINGLE_C;
                    end else if (beam_s) begin
                        list_pwr_r <= ins_pwr_s;
                        list_idx_r <= ins_idx_s;
                        list_vld_r <= ins_vld_s;
                        cnt_r      <= cnt_r + 7'd1;
                        if (cnt_r == CNT_LAST_C) begin
                            state_r <= ST_FLUSH;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_COLLECT;
                        end
                    end else begin
                        // Gap cycle: everything holds.
                        state_r    <= ST_COLLECT;
                    end
                end

                ST_FLUSH: begin
                    // Publish the completed list (old contents, even if a
                    // new RBG starts in this same cycle).
                    beam_idx_r <= list_idx_r;
                    beam_pwr_r <= list_pwr_r;
                    rbg_load_r <= 1'b1;
                    if (start_s) begin
                        list_pwr_r <= init_pwr_s;
                        list_idx_r <= init_idx_s;
                        list_vld_r <= init_vld_s;
                        cnt_r      <= 7'd1;
                        state_r    <= SINGLE_C ? ST_FLUSH : ST_COLLECT;
                        busy_r     <= !SINGLE_C;
                    end else if (beam_s) begin
                        err_sop_r  <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= 7'd0;
                    list_vld_r <= '0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign o_beam_idx = beam_idx_r;
    assign o_beam_pwr = beam_pwr_r;
    assign o_rbg_load = rbg_load_r;
    assign o_busy     = busy_r;
    assign o_err_sop  = err_sop_r;

endmodule

// File: tb/tb_beam_topk_sort.sv
// =============================================================================
// tb_beam_topk_sort
// Directed bench for beam_topk_sort. A behavioural model tracks RBG framing
// and computes the expected top-16 with a plain stable selection over the
// collected powers; a compare loop checks every output each cycle. Literal
// expectations per test pin the model.
// =============================================================================
module tb_beam_topk_sort;

    localparam int NB = 64;
    localparam int BK = 16;
    localparam int PW = 32;

    logic                     clk;
    logic                     rst_n;
    logic                     vld;
    logic                     sop;
    logic [PW-1:0]            data;
    logic [BK-1:0][7:0]       beam_idx;
    logic [BK-1:0][PW-1:0]    beam_pwr;
    logic                     rbg_load;
    logic                     busy;
    logic                     err_sop;

    beam_topk_sort #(.NBEAM_IN(NB), .BEAM(BK), .PWR_W(PW)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_pwr_vld  (vld),
        .i_pwr_sop  (sop),
        .i_pwr_data (data),
        .o_beam_idx (beam_idx),
        .o_beam_pwr (beam_pwr),
        .o_rbg_load (rbg_load),
        .o_busy     (busy),
        .o_err_sop  (err_sop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- behavioural model ----------------
    logic [PW-1:0]            m_samp [NB];
    int                       m_cnt;
    bit                       m_in_rbg;
    bit                       m_pend;
    bit                       m_valid = 1'b0;
    logic [BK-1:0][7:0]       pend_idx;
    logic [BK-1:0][PW-1:0]    pend_pwr;
    logic [BK-1:0][7:0]       exp_idx;
    logic [BK-1:0][PW-1:0]    exp_pwr;
    logic                     exp_load;
    logic                     exp_err;
    logic                     exp_busy;

    // Stable top-K: strongest first, earlier beam wins on equal power.
    function automatic void calc_topk();
        bit taken [NB];
        int best;
        for (int b = 0; b < NB; b++) taken[b] = 1'b0;
        for (int r = 0; r < BK; r++) begin
            best = -1;
            for (int b = 0; b < NB; b++) begin
                if (!taken[b]) begin
                    if (best < 0) best = b;
                    else if (m_samp[b] > m_samp[best]) best = b;
                end
            end
            taken[best] = 1'b1;
            pend_idx[r] = 8'(best);
            pend_pwr[r] = m_samp[best];
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_in_rbg = 1'b0;
            m_cnt    = 0;
            m_pend   = 1'b0;
            for (int i = 0; i < BK; i++) begin
                exp_idx[i] = 8'(i);
                exp_pwr[i] = '0;
            end
            exp_load = 1'b0;
            exp_err  = 1'b0;
            exp_busy = 1'b0;
        end else begin
            exp_load = 1'b0;
            exp_err  = 1'b0;
            if (m_pend) begin
                exp_idx  = pend_idx;
                exp_pwr  = pend_pwr;
                exp_load = 1'b1;
                m_pend   = 1'b0;
            end
            if (vld) begin
                if (sop) begin
                    if (m_in_rbg) exp_err = 1'b1;
                    m_samp[0] = data;
                    m_cnt     = 1;
                    m_in_rbg  = 1'b1;
                end else if (m_in_rbg) begin
                    m_samp[m_cnt] = data;
                    m_cnt         = m_cnt + 1;
                end else begin
                    exp_err = 1'b1;
                end
                if (m_in_rbg && m_cnt == NB) begin
                    calc_topk();
                    m_pend   = 1'b1;
                    m_in_rbg = 1'b0;
                end
            end
            exp_busy = m_in_rbg;
        end
        m_valid = 1'b1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int load_edges [$];
    int err_cnt;
    int last_edge;
    int le1;
    logic [PW-1:0] stim [NB];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("load",  rbg_load, exp_load);
                chk("err",   err_sop,  exp_err);
                chk("busy",  busy,     exp_busy);
                chk("idx",   beam_idx, exp_idx);
                chk("pwr",   beam_pwr, exp_pwr);
                if (rbg_load === 1'b1) load_edges.push_back(edge_cnt);
                if (err_sop === 1'b1) err_cnt = err_cnt + 1;
            end
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [PW-1:0] d);
        @(negedge clk);
        vld  = v;
        sop  = s;
        data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    task automatic send_rbg(input int gap_max);
        for (int b = 0; b < NB; b++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) drive(1'b0, 1'b0, '0);
            drive(1'b1, (b == 0), stim[b]);
            if (b == NB - 1) last_edge = edge_cnt + 1;
        end
    endtask

    task automatic clear_logs();
        load_edges.delete();
        err_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; sop = 1'b0; data = '0;
        err_cnt = 0; last_edge = 0; le1 = 0;
        fork
            compare_loop();
        join_none
        repeat (3) @(negedge clk);
        // Reset values
        for (int i = 0; i < BK; i++) begin
            chk("rst_idx", beam_idx[i], 8'(i));
            chk("rst_pwr", beam_pwr[i], '0);
        end
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // T1 ascending
        clear_logs();
        for (int b = 0; b < NB; b++) stim[b] = PW'(b);
        send_rbg(0);
        idle(5);
        chk("t1_nload", load_edges.size(), 1);
        chk("t1_lat", load_edges[0] - last_edge, 1);
        for (int i = 0; i < BK; i++) begin
            chk("t1_idx", beam_idx[i], 8'(63 - i));
            chk("t1_pwr", beam_pwr[i], PW'(63 - i));
        end

        // T2 descending
        clear_logs();
        for (int b = 0; b < NB; b++) stim[b] = PW'(1000 - b);
        send_rbg(0);
        idle(5);
        chk("t2_nload", load_edges.size(), 1);
        for (int i = 0; i < BK; i++) chk("t2_idx", beam_idx[i], 8'(i));
        chk("t2_pwr0", beam_pwr[0], PW'(1000));

        // T3 ties
        clear_logs();
        for (int b = 0; b < NB; b++) stim[b] = PW'(5);
        send_rbg(0);
        idle(5);
        for (int i = 0; i < BK; i++) chk("t3_idx", beam_idx[i], 8'(i));

        // T4 random powers with duplicates and random gaps
        clear_logs();
        for (int b = 0; b < NB; b++) stim[b] = PW'($urandom_range(0, 50));
        send_rbg(3);
        idle(5);
        chk("t4_nload", load_edges.size(), 1);
        chk("t4_lat", load_edges[0] - last_edge, 1);

        // T5 early sop after 10 samples, then full RBG peaking at beam 40
        clear_logs();
        for (int b = 0; b < 10; b++) drive(1'b1, (b == 0), PW'(100 + b));
        for (int b = 0; b < NB; b++) stim[b] = (b == 40) ? PW'(5000) : PW'(b);
        send_rbg(0);
        idle(5);
        chk("t5_nerr", err_cnt, 1);
        chk("t5_nload", load_edges.size(), 1);
        chk("t5_idx0", beam_idx[0], 8'd40);
        chk("t5_pwr0", beam_pwr[0], PW'(5000));
        chk("t5_idx1", beam_idx[1], 8'd63);

        // T6 back-to-back RBGs, second sop in the FLUSH cycle
        clear_logs();
        for (int b = 0; b < NB; b++) stim[b] = PW'(b);
        send_rbg(0);
        le1 = last_edge;
        for (int b = 0; b < NB; b++) stim[b] = PW'(1000 - b);
        send_rbg(0);
        idle(5);
        chk("t6_nload", load_edges.size(), 2);
        chk("t6_lat", load_edges[0] - le1, 1);
        chk("t6_gap", load_edges[1] - load_edges[0], 64);
        chk("t6_nerr", err_cnt, 0);
        chk("t6_idx0", beam_idx[0], 8'd0);

        // Stray beam in IDLE, and stray beam in the FLUSH cycle
        clear_logs();
        drive(1'b1, 1'b0, PW'(7));
        idle(3);
        chk("idle_err", err_cnt, 1);
        chk("idle_nload", load_edges.size(), 0);
        clear_logs();
        for (int b = 0; b < NB; b++) stim[b] = PW'(b);
        send_rbg(0);
        drive(1'b1, 1'b0, PW'(9));
        idle(4);
        chk("flush_err", err_cnt, 1);
        chk("flush_nload", load_edges.size(), 1);
        chk("flush_busy", busy, 1'b0);

        // Reset at sample 30 discards the RBG
        clear_logs();
        for (int b = 0; b < 30; b++) drive(1'b1, (b == 0), PW'(b + 1));
        @(negedge clk);
        vld = 1'b0; sop = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(70);
        chk("rstm_nload", load_edges.size(), 0);
        for (int i = 0; i < BK; i++) chk("rstm_idx", beam_idx[i], 8'(i));
        chk("rstm_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
